// File: rtl/overlay_mem_pkg.sv
// Shared types and constants for the overlay memory arbiter:
// arbiter states, default prefetch depth and pixel nibble positions.
package overlay_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  // pix_data layout {a,b,g,r}
  localparam int PIX_FIELD_W = 4;
  localparam int PIX_R_LSB   = 0;
  localparam int PIX_G_LSB   = 4;
  localparam int PIX_B_LSB   = 8;
  localparam int PIX_A_LSB   = 12;

endpackage

// File: rtl/ovl_prefetch_fifo.sv
// Synchronous 32-bit prefetch FIFO with flush and occupancy count;
// the head word is read combinationally so the pixel stage can use it directly.
module ovl_prefetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [31:0]             push_data,
  input  logic                    pop,
  output logic [31:0]             head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // flush wins over anything arriving in the same cycle
  assign do_push = push & ~flush & (count != CW'(DEPTH));
  assign do_pop  = pop & ~flush & ~empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/overlay_mem_arbiter.sv
// Arbitrates one memory port between overlay download writes (byte-paired,
// priority) and 32-bit pixel prefetch reads feeding the pixel output stage.
module overlay_mem_arbiter
  import overlay_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ovl_en,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        vs,
  input  logic        de,
  input  logic        pix_ce,
  output logic [15:0] pix_data,
  output logic        underrun,
  output logic        mem_req,
  output logic        mem_rnw,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  arb_state_t state, state_next;

  logic        vs_d, dl_active_d;
  logic        vs_rise, dl_rise, flush;
  logic        pair_wr, write_done, read_done;
  logic [7:0]  low_byte;
  logic        pend_valid, skid_valid;
  logic [23:0] pend_addr, skid_addr;
  logic [15:0] pend_data, skid_data;
  logic [23:0] rd_ptr;
  logic        rd_discard;
  logic        sel;

  logic        mem_req_next, mem_rnw_next;
  logic [23:0] mem_addr_next;
  logic [15:0] mem_wdata_next;

  logic        fifo_push, fifo_pop, fifo_empty;
  logic [31:0] fifo_head;
  logic [CW-1:0] fifo_count;

  assign vs_rise    = vs & ~vs_d;
  assign dl_rise    = dl_active & ~dl_active_d;
  assign flush      = vs_rise | dl_rise;
  assign pair_wr    = dl_wr & dl_addr[0];
  assign write_done = (state == WR_WAIT) & mem_ack;
  assign read_done  = (state == RD_WAIT) & mem_ack;
  assign fifo_push  = read_done & ~rd_discard & ~flush & ovl_en;
  assign fifo_pop   = ovl_en & pix_ce & de & ~fifo_empty & sel & ~flush;

  ovl_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_rnw   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_next;
      mem_req   <= mem_req_next;
      mem_rnw   <= mem_rnw_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
    end
  end

  always_comb begin
    state_next     = state;
    mem_req_next   = 1'b0;
    mem_rnw_next   = mem_rnw;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    case (state)
      IDLE: begin
        if (pend_valid && !dl_rise) begin
          state_next     = WR_WAIT;
          mem_req_next   = 1'b1;
          mem_rnw_next   = 1'b0;
          mem_addr_next  = pend_addr;
          mem_wdata_next = pend_data;
        end else if (ovl_en && !dl_active && !flush && (fifo_count < CW'(FIFO_DEPTH))) begin
          // only issued from IDLE, so nothing else is in flight here
          state_next    = RD_WAIT;
          mem_req_next  = 1'b1;
          mem_rnw_next  = 1'b1;
          mem_addr_next = rd_ptr;
        end
      end
      WR_WAIT: if (mem_ack) state_next = IDLE;
      RD_WAIT: if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Download byte pairing with a one-deep skid behind the pending write
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      low_byte   <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      skid_data  <= '0;
    end else if (dl_rise) begin
      low_byte   <= '0;
      pend_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (dl_wr && !dl_addr[0]) low_byte <= dl_data;
      if (write_done) begin
        if (skid_valid) begin
          pend_addr  <= skid_addr;
          pend_data  <= skid_data;
          skid_valid <= 1'b0;
          if (pair_wr) begin
            skid_valid <= 1'b1;
            skid_addr  <= dl_addr[24:1];
            skid_data  <= {dl_data, low_byte};
          end
        end else if (pair_wr) begin
          pend_addr <= dl_addr[24:1];
          pend_data <= {dl_data, low_byte};
        end else begin
          pend_valid <= 1'b0;
        end
      end else if (pair_wr) begin
        if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend_addr  <= dl_addr[24:1];
          pend_data  <= {dl_data, low_byte};
        end else if (!skid_valid) begin
          skid_valid <= 1'b1;
          skid_addr  <= dl_addr[24:1];
          skid_data  <= {dl_data, low_byte};
        end
      end
    end
  end

  // Read pointer, edge detectors and discard marking for reads made stale mid-flight
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vs_d        <= 1'b0;
      dl_active_d <= 1'b0;
      rd_ptr      <= '0;
      rd_discard  <= 1'b0;
    end else begin
      vs_d        <= vs;
      dl_active_d <= dl_active;
      if (flush)          rd_ptr <= '0;
      else if (fifo_push) rd_ptr <= rd_ptr + 24'd2;
      if (state_next != RD_WAIT)                        rd_discard <= 1'b0;
      else if (state == RD_WAIT && (flush || !ovl_en)) rd_discard <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pix_data <= '0;
      underrun <= 1'b0;
      sel      <= 1'b0;
    end else begin
      if (!ovl_en) begin
        pix_data <= '0;
      end else if (pix_ce && de) begin
        if (fifo_empty) begin
          pix_data <= '0;
          underrun <= 1'b1;
        end else begin
          pix_data <= sel ? fifo_head[31:16] : fifo_head[15:0];
          sel      <= ~sel;
        end
      end
      if (flush)   sel      <= 1'b0;
      if (vs_rise) underrun <= 1'b0;
    end
  end

endmodule

// File: doc/overlay_mem_arbiter.md
OVERLAY_MEM_ARBITER -- requirements
Module: overlay_mem_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 32-bit prefetch entries (power of two, 2..16).
REQ-002 clk_sys  in  1  single clock, all logic rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ovl_en  in  1  overlay enabled; 0 forces pix_data=0 and suppresses reads.
REQ-005 dl_active  in  1  overlay download in progress.
REQ-006 dl_wr  in  1  download byte strobe, one cycle.
REQ-007 dl_addr  in  25  download byte address.
REQ-008 dl_data  in  8  download byte.
REQ-009 vs  in  1  vertical sync, active high.
REQ-010 de  in  1  display enable (~(hblank|vblank)).
REQ-011 pix_ce  in  1  pixel clock enable.
REQ-012 pix_data  out  16  overlay pixel {a,b,g,r}, 4 bits each.
REQ-013 underrun  out  1  sticky: pixel requested while FIFO empty this frame.
REQ-014 mem_req  out  1  memory request, one-cycle pulse.
REQ-015 mem_rnw  out  1  1=read, 0=write; valid with mem_req.
REQ-016 mem_addr  out  24  16-bit word address (byte address [24:1]).
REQ-017 mem_wdata  out  16  write data {odd byte, even byte}.
REQ-018 mem_rdata  in  32  read data, two consecutive words, lower word in [15:0].
REQ-019 mem_ack  in  1  one-cycle completion pulse; mem_rdata valid that cycle for reads.

Function
REQ-020 FSM states IDLE, WR_WAIT, RD_WAIT; at most one request outstanding.
REQ-021 Byte pairing: dl_wr with dl_addr[0]=0 latches dl_data into a low-byte register; dl_wr with dl_addr[0]=1 forms a pending write {dl_data, low byte} at dl_addr[24:1].
REQ-022 IDLE with pending write: pulse mem_req, mem_rnw=0, go WR_WAIT; mem_ack returns to IDLE and clears pending.
REQ-023 A new paired byte arriving while a write is pending or in WR_WAIT overwrites nothing; it is held in a one-entry skid register, and a third arrival before drain sets no flag and is dropped (download source guarantees ≥8 cycles per byte).
REQ-024 Writes have strict priority over reads; reads are never issued while dl_active=1.
REQ-025 IDLE with ovl_en=1, dl_active=0, no pending write, and (FIFO count + in-flight) < FIFO_DEPTH: pulse mem_req, mem_rnw=1, mem_addr=rd_ptr, go RD_WAIT.
REQ-026 RD_WAIT: mem_ack pushes mem_rdata into FIFO, rd_ptr += 2, returns to IDLE.
REQ-027 rd_ptr is 24 bits and wraps from 0xFFFFFE to 0x000000.
REQ-028 Rising edge of vs (registered compare): flush FIFO, rd_ptr=0, clear underrun, clear halfword select; a read in flight at that moment completes but its data is discarded.
REQ-029 pix_ce & de: pix_data takes the FIFO head's [15:0] when select=0, [31:16] when select=1; select toggles; FIFO pops after the high half.
REQ-030 pix_ce & de with FIFO empty: pix_data=0, underrun=1, select unchanged.
REQ-031 pix_ce & ~de: pix_data holds; no pop.
REQ-032 Push and pop in the same cycle leave count unchanged; push while full never occurs by REQ-025.
REQ-033 dl_active rising edge: flush FIFO, rd_ptr=0, clear low-byte, pending and skid registers.
REQ-034 ovl_en=0: pix_data=0 registered next cycle; in-flight read completes and is discarded.

Reset
REQ-035 reset_n=0 asynchronously: FSM=IDLE, mem_req=0, mem_rnw=1, mem_addr=0, mem_wdata=0, pix_data=0, underrun=0, FIFO empty, rd_ptr=0, select=0, pending/skid clear.
REQ-036 Reset asserted mid-request abandons it; a mem_ack arriving after reset release with no request outstanding is ignored.

Structure
REQ-037 Package overlay_mem_pkg holds the state enum, default FIFO_DEPTH, and the pixel field offsets (r=3:0, g=7:4, b=11:8, a=15:12).
REQ-038 Sub-module ovl_prefetch_fifo (synchronous 32-bit FIFO with push, pop, flush, count) is instantiated once.

Verification
REQ-039 Download bytes 0x11@0, 0x22@1 -> one write, mem_addr=0, mem_wdata=0x2211, mem_rnw=0.
REQ-040 ovl_en=1, vs pulse, memory returns 0xBBBBAAAA then 0xDDDDCCCC -> four pixels with de give 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD; reads at addresses 0, 2.
REQ-041 Memory ack withheld, 3 pixels requested -> pix_data=0, underrun=1; next vs rising clears underrun.
REQ-042 vs rising edge during RD_WAIT -> late data dropped, next read at mem_addr=0, first pixel from new data.
REQ-043 dl_active=1 with FIFO not full -> no read requests; write issued within 2 cycles of pairing.
REQ-044 reset_n low during WR_WAIT -> outputs at reset values immediately; stray mem_ack after release causes no FIFO push.
